// File: rtl/keyboard_pkg.sv
// rtl/keyboard_pkg.sv - shared constants and key indexing for the keypad scanner
// Purpose: matrix geometry, default timing parameters and the (col,row) -> key index map.
// Ports: none (package).
package keyboard_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam int DEFAULT_SCAN_DIV     = 50000;
  localparam int DEFAULT_DEBOUNCE_CNT = 20;

  function automatic int key_idx(input int col, input int row);
    return col * NUM_ROWS + row;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key frame-based debounce with press-edge pulse
// Purpose: tracks one key's debounced level; a level change needs DEBOUNCE_CNT
//          consecutive frames of a disagreeing raw sample.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   frame_done   one-cycle strobe after a full matrix scan
//   raw_bit      this key's latest raw sample (1 = pressed)
//   state_bit    debounced level (1 = held)
//   press_pulse  one-cycle pulse coinciding with the first cycle state_bit reads 1
module key_debounce
  import keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic rstn,
  input  logic frame_done,
  input  logic raw_bit,
  output logic state_bit,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      state_bit   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (frame_done) begin
        if (raw_bit == state_bit) begin
          // Agreement (including a bounce back) discards any partial count.
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          state_bit   <= raw_bit;
          cnt         <= '0;
          // Registered alongside the state so the pulse lines up with the rise.
          press_pulse <= raw_bit;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keyboard_scan.sv
// rtl/keyboard_scan.sv - 4x4 matrix keypad scanner with per-key debounce
// Purpose: drives one column low at a time, samples rows via a 2-FF synchronizer
//          at the end of each column period, and debounces all 16 keys per frame.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   row_in      keypad rows, pulled up; 0 = pressed key in the driven column
//   col_out     active-low column drive, exactly one bit low
//   key_pluse   one-cycle press pulses, index = col*4 + row
//   key_state   debounced key levels, 1 = held
module keyboard_scan
  import keyboard_pkg::*;
#(
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [NUM_KEYS-1:0] key_pluse,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]       prescaler;
  logic                tick;
  logic [1:0]          col_idx;
  logic [1:0]          col_next;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [NUM_KEYS-1:0] raw;
  logic                frame_done;

  assign tick     = (prescaler == PRE_LAST);
  assign col_next = col_idx + 2'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler <= '0;
      col_idx   <= 2'd0;
      col_out   <= 4'b1110;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        col_idx <= col_next;
        col_out <= ~(4'b0001 << col_next);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Sampling on the last cycle of a column period leaves the rows the whole
  // period (minus synchronizer latency) to settle after the column switch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raw        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (col_idx == 2'd3);
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          if (tick && (col_idx == 2'(c))) begin
            raw[key_idx(c, r)] <= ~row_sync[r];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
      .clk        (clk),
      .rstn       (rstn),
      .frame_done (frame_done),
      .raw_bit    (raw[k]),
      .state_bit  (key_state[k]),
      .press_pulse(key_pluse[k])
    );
  end

endmodule

// File: tb/tb_keyboard_scan.sv
// tb/tb_keyboard_scan.sv - scoreboard testbench for keyboard_scan
module tb_keyboard_scan;
  import keyboard_pkg::*;

  localparam int SD    = 8;
  localparam int DC    = 3;
  localparam int FRAME = 4 * SD;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_pluse;
  logic [15:0] key_state;
  logic [15:0] pressed = '0;

  always #5 clk = ~clk;

  // Keypad: a row reads low when a pressed key sits on it in the driven column.
  always_comb begin
    row_in = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
  end

  keyboard_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_pluse(key_pluse),
    .key_state(key_state)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t pq[$];
  exp_t sq[$];
  int   cyc = 0;

  // Frame-level reference: per key, length of the current run of frames whose
  // sample disagrees with the debounced level.
  logic [15:0] m_state;
  int          m_run[16];
  int          fj;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  exp_t       mon_e;
  logic [3:0] mon_col;
  logic [3:0] one4 = 4'b0001;

  always @(negedge clk) begin
    if (!rstn) begin
      check("reset col_out", 16'(col_out), 16'h000e);
      check("reset key_pluse", key_pluse, 16'h0000);
      check("reset key_state", key_state, 16'h0000);
    end else begin
      mon_col = ~(one4 << ((cyc / SD) % 4));
      check("col_out", 16'(col_out), 16'(mon_col));
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        mon_e = pq.pop_front();
        check("key_pluse", key_pluse, mon_e.val);
      end else if (key_pluse != 16'h0) begin
        check("unexpected key_pluse", key_pluse, 16'h0000);
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        mon_e = sq.pop_front();
        check("key_state", key_state, mon_e.val);
      end
    end
  end

  task automatic model_frame(input logic [15:0] vec);
    logic [15:0] pulse;
    exp_t        e;
    pulse = '0;
    for (int k = 0; k < 16; k++) begin
      if (vec[k] == m_state[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k]++;
        if (m_run[k] == DC) begin
          m_state[k] = vec[k];
          m_run[k]   = 0;
          if (vec[k]) pulse[k] = 1'b1;
        end
      end
    end
    e.cyc = FRAME * (fj + 1) + 1;
    e.val = m_state;
    sq.push_back(e);
    if (pulse != 16'h0) begin
      e.val = pulse;
      pq.push_back(e);
    end
    fj++;
  endtask

  // Called shortly after a posedge; pulls reset low asynchronously.
  task automatic do_reset(input int hold);
    rstn = 1'b0;
    #1;
    check("async reset col_out", 16'(col_out), 16'h000e);
    check("async reset key_state", key_state, 16'h0000);
    check("async reset key_pluse", key_pluse, 16'h0000);
    pq.delete();
    sq.delete();
    m_state = '0;
    for (int k = 0; k < 16; k++) m_run[k] = 0;
    fj = 0;
    repeat (hold) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic run_frame(input logic [15:0] vec);
    pressed = vec;
    model_frame(vec);
    repeat (FRAME) @(posedge clk);
    #2;
  endtask

  task automatic run_frames(input logic [15:0] vec, input int n);
    for (int i = 0; i < n; i++) run_frame(vec);
  endtask

  task automatic partial_then_reset(input logic [15:0] vec, input int n, input int hold);
    pressed = vec;
    repeat (n) @(posedge clk);
    #2;
    do_reset(hold);
  endtask

  logic [15:0] rvec;

  initial begin
    @(posedge clk);
    #2;
    do_reset(3);

    // Idle scanning, then a reset landing mid-frame, then idle again.
    run_frames(16'h0000, 1);
    partial_then_reset(16'h0000, 13, 4);
    run_frames(16'h0000, 10);

    // Clean press and release of key 9.
    run_frames(16'h0200, 14);
    run_frames(16'h0000, 5);

    // Bouncing key 0 never reaches the debounce threshold.
    run_frame(16'h0001); run_frame(16'h0001); run_frame(16'h0000);
    run_frame(16'h0001); run_frame(16'h0001);
    run_frames(16'h0000, 4);

    // Simultaneous press of keys 0 and 15.
    run_frames(16'h8001, 5);
    run_frames(16'h0000, 5);

    // Key 5 held through a reset pulses again afterwards.
    run_frames(16'h0020, 2);
    partial_then_reset(16'h0020, 7, 5);
    run_frames(16'h0020, 5);
    run_frames(16'h0000, 5);

    // Repeated press of key 10.
    run_frames(16'h0400, 3);
    run_frames(16'h0000, 5);
    run_frames(16'h0400, 4);
    run_frames(16'h0000, 5);

    // Random per-frame toggling: mixes stable presses, releases and bounces.
    rvec = '0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 16; k++)
        if ($urandom_range(4) == 0) rvec[k] = ~rvec[k];
      run_frame(rvec);
    end
    run_frames(16'h0000, 4);

    repeat (3) @(posedge clk);
    #2;
    check("pending pulse expectations", 16'(pq.size()), 16'h0000);
    check("pending state expectations", 16'(sq.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
